// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame bit levels
// and parity-type encodings common to transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer and three-sample majority window for uart_rx.
// The window is positioned around the bit centre by the caller's counter.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    localparam int CW = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_in,
    input  logic [CW-1:0] sample_cnt,
    output logic          rx_sync,
    output logic          sampled_bit,
    output logic          sample_strobe
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic s0_q, s0_d;
    logic s1_q, s1_d;

    always_comb begin
        sync1_d = rx_in;
        sync2_d = sync1_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        if (sample_cnt == CW'(OVERSAMPLE / 2 - 1)) begin
            s0_d = sync2_q;
        end
        if (sample_cnt == CW'(OVERSAMPLE / 2)) begin
            s1_d = sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= STOP_BIT;
            sync2_q <= STOP_BIT;
            s0_q    <= STOP_BIT;
            s1_q    <= STOP_BIT;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
        end
    end

    // Third sample is the live synchronized value in the decision cycle
    assign rx_sync       = sync2_q;
    assign sample_strobe = (sample_cnt == CW'(OVERSAMPLE / 2 + 1));
    assign sampled_bit   = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/parity/stop framing with
// one-cycle result pulses for good words, parity and stop errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int size       = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            RXIn,
    input  logic            ParityEn,
    input  logic            ParityType,
    output logic [size-1:0] ParallelData,
    output logic            DataValid,
    output logic            ParityError,
    output logic            StopError,
    output logic            Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (size > 1) ? $clog2(size) : 1;

    rx_state_e       state_q, state_d;
    logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [size-1:0] shift_q, shift_d;
    logic [size-1:0] data_q, data_d;
    logic            par_en_q, par_en_d;
    logic            par_type_q, par_type_d;
    logic            par_bit_q, par_bit_d;
    logic            dv_q, dv_d;
    logic            perr_q, perr_d;
    logic            serr_q, serr_d;

    logic rx_sync;
    logic sampled_bit;
    logic sample_strobe;
    logic bit_end;
    logic par_exp;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk          (CLK),
        .rst          (RST),
        .rx_in        (RXIn),
        .sample_cnt   (sample_cnt_q),
        .rx_sync      (rx_sync),
        .sampled_bit  (sampled_bit),
        .sample_strobe(sample_strobe)
    );

    assign bit_end = (sample_cnt_q == CW'(OVERSAMPLE - 1));
    assign par_exp = (^shift_q) ^ (par_type_q == PARITY_ODD);

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = bit_end ? '0 : sample_cnt_q + CW'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        par_en_d     = par_en_q;
        par_type_d   = par_type_q;
        par_bit_d    = par_bit_q;
        dv_d         = 1'b0;
        perr_d       = 1'b0;
        serr_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                sample_cnt_d = '0;
                if (rx_sync == START_BIT) begin
                    par_en_d     = ParityEn;
                    par_type_d   = ParityType;
                    bit_cnt_d    = '0;
                    sample_cnt_d = CW'(1);
                    state_d      = START;
                end
            end
            START: begin
                if (sample_strobe && sampled_bit != START_BIT) begin
                    sample_cnt_d = '0;
                    state_d      = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_strobe) begin
                    shift_d = {sampled_bit, shift_q[size-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == BW'(size - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (sample_strobe) begin
                    par_bit_d = sampled_bit;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave at the decision so back-to-back frames get half a bit of slack
                if (sample_strobe) begin
                    sample_cnt_d = '0;
                    state_d      = IDLE;
                    if (sampled_bit != STOP_BIT) begin
                        serr_d = 1'b1;
                    end else if (par_en_q && par_bit_q != par_exp) begin
                        perr_d = 1'b1;
                    end else begin
                        dv_d   = 1'b1;
                        data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            par_bit_q    <= 1'b0;
            dv_q         <= 1'b0;
            perr_q       <= 1'b0;
            serr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            par_type_q   <= par_type_d;
            par_bit_q    <= par_bit_d;
            dv_q         <= dv_d;
            perr_q       <= perr_d;
            serr_q       <= serr_d;
        end
    end

    assign ParallelData = data_q;
    assign DataValid    = dv_q;
    assign ParityError  = perr_q;
    assign StopError    = serr_q;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at size=8, OVERSAMPLE=8.
// Frames are driven bit by bit; a negedge monitor tallies output pulses.
module tb_uart_rx;

    logic       CLK;
    logic       RST;
    logic       RXIn;
    logic       ParityEn;
    logic       ParityType;
    logic [7:0] ParallelData;
    logic       DataValid;
    logic       ParityError;
    logic       StopError;
    logic       Busy;

    uart_rx #(
        .size      (8),
        .OVERSAMPLE(8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RXIn        (RXIn),
        .ParityEn    (ParityEn),
        .ParityType  (ParityType),
        .ParallelData(ParallelData),
        .DataValid   (DataValid),
        .ParityError (ParityError),
        .StopError   (StopError),
        .Busy        (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         dv_n = 0, pe_n = 0, se_n = 0, multi = 0;
    int         busy_n = 0, busy_first = 0, busy_last = 0, dv_cyc = 0;
    logic       busy_p = 1'b0;
    logic [7:0] dv_data [16];

    always @(negedge CLK) begin
        busy_p <= Busy;
        if (Busy) begin
            busy_n    <= busy_n + 1;
            busy_last <= cyc;
            if (!busy_p) busy_first <= cyc;
        end
        if (DataValid) begin
            dv_data[dv_n % 16] <= ParallelData;
            dv_cyc             <= cyc;
            dv_n               <= dv_n + 1;
        end
        if (ParityError) pe_n <= pe_n + 1;
        if (StopError) se_n <= se_n + 1;
        if (int'(DataValid) + int'(ParityError) + int'(StopError) > 1)
            multi <= multi + 1;
    end

    int vec = 0;
    int miss = 0;
    int t0 = 0;
    int s_dv, s_pe, s_se, s_busy, s_multi;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        s_dv    = dv_n;
        s_pe    = pe_n;
        s_se    = se_n;
        s_busy  = busy_n;
        s_multi = multi;
    endtask

    // jit: 0 none, +1 even bits one cycle long / odd short, -1 the reverse
    // gk: bit index receiving a one-cycle inverted sample mid-bit
    // abort_k: bit index during which RST pulses and the frame is dropped
    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic pbit, input logic sbit,
                              input int jit, input int gk,
                              input int abort_k);
        logic b;
        int   nb;
        int   len;
        nb = pen ? 11 : 10;
        t0 = cyc;
        for (int k = 0; k < nb; k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= 8) b = d[k-1];
            else if (pen && k == 9) b = pbit;
            else b = sbit;
            len = 8 + ((jit == 0) ? 0 : ((k % 2 == 0) ? jit : -jit));
            for (int m = 0; m < len; m++) begin
                if (k == abort_k && m == 2) begin
                    chk("busy_pre_rst", 32'(Busy), 1);
                    RST = 1'b1;
                    @(posedge CLK);
                    #1;
                    RST  = 1'b0;
                    RXIn = 1'b1;
                    return;
                end
                RXIn = (k == gk && m == 4) ? ~b : b;
                @(posedge CLK);
                #1;
            end
        end
        RXIn = 1'b1;
    endtask

    initial begin
        RST        = 1'b1;
        RXIn       = 1'b1;
        ParityEn   = 1'b0;
        ParityType = 1'b0;
        wait_cyc(3);
        @(negedge CLK);
        chk("rst_data", 32'(ParallelData), 0);
        chk("rst_dv", 32'(DataValid), 0);
        chk("rst_perr", 32'(ParityError), 0);
        chk("rst_serr", 32'(StopError), 0);
        chk("rst_busy", 32'(Busy), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_cyc(4);

        // 0xA5, no parity: full timing check
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, -1, -1);
        wait_cyc(12);
        chk("a5_dv_n", dv_n - s_dv, 1);
        chk("a5_dv_cyc", dv_cyc - t0, 80);
        chk("a5_data", 32'(ParallelData), 32'hA5);
        chk("a5_pe", pe_n - s_pe, 0);
        chk("a5_se", se_n - s_se, 0);
        chk("a5_busy_first", busy_first - t0, 3);
        chk("a5_busy_last", busy_last - t0, 79);
        chk("a5_busy_n", busy_n - s_busy, 77);
        chk("a5_multi", multi - s_multi, 0);

        // even parity
        ParityEn   = 1'b1;
        ParityType = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 0, -1, -1);
        wait_cyc(12);
        chk("3c_dv_n", dv_n - s_dv, 1);
        chk("3c_dv_cyc", dv_cyc - t0, 88);
        chk("3c_data", 32'(ParallelData), 32'h3C);
        chk("3c_pe", pe_n - s_pe, 0);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0, -1, -1);
        wait_cyc(12);
        chk("3c_bad_pe", pe_n - s_pe, 1);
        chk("3c_bad_dv", dv_n - s_dv, 0);
        chk("3c_bad_se", se_n - s_se, 0);
        chk("3c_bad_data", 32'(ParallelData), 32'h3C);

        // odd parity, then stop error masking a parity error
        ParityType = 1'b1;
        snap();
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, 0, -1, -1);
        wait_cyc(12);
        chk("01_dv_n", dv_n - s_dv, 1);
        chk("01_data", 32'(ParallelData), 32'h01);
        chk("01_pe", pe_n - s_pe, 0);
        snap();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 0, -1, -1);
        wait_cyc(20);
        chk("stop_se", se_n - s_se, 1);
        chk("stop_pe", pe_n - s_pe, 0);
        chk("stop_dv", dv_n - s_dv, 0);
        chk("stop_data", 32'(ParallelData), 32'h01);
        chk("stop_busy_end", 32'(Busy), 0);

        // short start glitch
        ParityEn = 1'b0;
        snap();
        RXIn = 1'b0;
        wait_cyc(2);
        RXIn = 1'b1;
        wait_cyc(15);
        chk("glitch_dv", dv_n - s_dv, 0);
        chk("glitch_pe", pe_n - s_pe, 0);
        chk("glitch_se", se_n - s_se, 0);
        chk("glitch_busy_n", busy_n - s_busy, 5);
        snap();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 0, -1, -1);
        wait_cyc(12);
        chk("ff_dv_n", dv_n - s_dv, 1);
        chk("ff_data", 32'(ParallelData), 32'hFF);

        // back-to-back with bit-edge jitter
        snap();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1, -1, -1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        wait_cyc(12);
        chk("b2b_dv_n", dv_n - s_dv, 2);
        chk("b2b_data0", 32'(dv_data[s_dv % 16]), 32'h12);
        chk("b2b_data1", 32'(dv_data[(s_dv + 1) % 16]), 32'h34);
        chk("b2b_err", (pe_n - s_pe) + (se_n - s_se), 0);

        // single-sample spikes inside the majority window
        snap();
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 0, 1, -1);
        wait_cyc(12);
        chk("spike1_dv_n", dv_n - s_dv, 1);
        chk("spike1_data", 32'(ParallelData), 32'h0F);
        snap();
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 0, 8, -1);
        wait_cyc(12);
        chk("spike8_dv_n", dv_n - s_dv, 1);
        chk("spike8_data", 32'(dv_data[s_dv % 16]), 32'h0F);

        // reset during data bit 4
        snap();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, -1, 5);
        @(negedge CLK);
        chk("rst_mid_busy", 32'(Busy), 0);
        chk("rst_mid_dv", 32'(DataValid), 0);
        wait_cyc(20);
        chk("rst_mid_pulses",
            (dv_n - s_dv) + (pe_n - s_pe) + (se_n - s_se), 0);
        snap();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 0, -1, -1);
        wait_cyc(12);
        chk("5a_dv_n", dv_n - s_dv, 1);
        chk("5a_data", 32'(ParallelData), 32'h5A);
        chk("final_multi", multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
